// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: walks a register file through one async read port and streams each word out as a valid/ready beat.
// Optional feature: define REGDUMP_CHECKSUM_EN to append an XOR checksum beat (idx 0, last) after the final register.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start_i               begin a dump; honoured only while idle
//   busy_o                dump in progress (READ, SEND or CSUM)
//   done_o                one-cycle pulse after the final beat's handshake
//   ra_o, rd_i            register-file read address / combinational read data
//   out_valid_o/ready_i   beat handshake
//   out_data_o, out_idx_o beat payload and its register index
//   out_last_o            marks the final beat of the dump
module regfile_dump_ctrl #(
  parameter int NREGS = 32,
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] ra_o,
  input  logic [DW-1:0] rd_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic [AW-1:0] out_idx_o,
  output logic          out_last_o
);
`ifdef REGDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;
`endif
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
  state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d, oidx_q, oidx_d;
  logic [DW-1:0] data_q, data_d;
  logic valid_q, valid_d, last_q, last_d, hs;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;
`endif
  assign hs = valid_q && out_ready_i;
  assign ra_o = (state_q == READ) ? idx_q : '0;
  assign busy_o = (state_q != IDLE) && (state_q != DONE);
  assign done_o = (state_q == DONE);
  assign out_valid_o = valid_q;
  assign out_data_o = data_q;
  assign out_idx_o = oidx_q;
  assign out_last_o = last_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      oidx_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      oidx_q <= oidx_d;
      data_q <= data_d;
      valid_q <= valid_d;
      last_q <= last_d;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    oidx_d = oidx_q;
    data_d = data_q;
    valid_d = valid_q;
    last_d = last_q;
`ifdef REGDUMP_CHECKSUM_EN
    csum_d = csum_q;
`endif
    unique case (state_q)
      IDLE: if (start_i) begin
        idx_d = '0;
`ifdef REGDUMP_CHECKSUM_EN
        csum_d = '0;
`endif
        state_d = READ;
      end
      READ: begin
        data_d = rd_i;
        oidx_d = idx_q;
        valid_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
        csum_d = csum_q ^ rd_i;
        last_d = 1'b0;
`else
        last_d = (idx_q == LAST);
`endif
        state_d = SEND;
      end
      SEND: if (hs) begin
        valid_d = 1'b0;
        last_d = 1'b0;
        if (idx_q == LAST) begin
`ifdef REGDUMP_CHECKSUM_EN
          // checksum already folds in the last word at its READ edge, so the extra beat can go out immediately
          data_d = csum_q;
          oidx_d = '0;
          last_d = 1'b1;
          valid_d = 1'b1;
          state_d = CSUM;
`else
          state_d = DONE;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
          state_d = READ;
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      CSUM: if (hs) begin
        valid_d = 1'b0;
        last_d = 1'b0;
        state_d = DONE;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule
